// File: rtl/keypad_scan_fsm.sv
// keypad_scan_fsm: NUM_ROWS x NUM_COLS matrix-keypad scanner with press/release
// debounce, encoded key code output and optional typematic auto-repeat.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   row_synced in   synchronised row lines, 1 = key in strobed column pressed
//   repeat_en  in   enables auto-repeat while a key is held
//   col        out  one-hot column strobe
//   key_code   out  row_idx*NUM_COLS + col_idx of the last accepted key
//   valid_key  out  one-cycle pulse per accepted press or repeat
//   key_held   out  high while a key is accepted and not yet released
module keypad_scan_fsm #(
  parameter int unsigned NUM_ROWS        = 4,
  parameter int unsigned NUM_COLS        = 4,
  parameter int unsigned SCAN_DIV        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 24000000,
  parameter int unsigned REPEAT_PERIOD   = 6000000
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_ROWS-1:0]                   row_synced,
  input  logic                                  repeat_en,
  output logic [NUM_COLS-1:0]                   col,
  output logic [$clog2(NUM_ROWS*NUM_COLS)-1:0]  key_code,
  output logic                                  valid_key,
  output logic                                  key_held
);

  localparam int unsigned ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int unsigned COL_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int unsigned KEY_W   = $clog2(NUM_ROWS*NUM_COLS);
  localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
  localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

  typedef enum logic [2:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_DRIVE,
    ST_HOLD,
    ST_RELEASE
  } state_t;

  state_t            state;
  logic [SCAN_W-1:0] scan_cnt;
  logic [DEB_W-1:0]  deb_cnt;
  logic [REP_W-1:0]  rep_cnt;
  logic              rep_first_done;
  logic [ROW_W-1:0]  row_idx;
  logic [COL_W-1:0]  col_idx;
  logic              row_hit;
  logic [REP_W-1:0]  rep_last;

  // Only the latched row matters once a candidate key is found.
  assign row_hit  = row_synced[row_idx];
  // First repeat waits REPEAT_DELAY held cycles, later ones REPEAT_PERIOD.
  assign rep_last = rep_first_done ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);

  // Lowest set row index wins when several rows of one column are active.
  function automatic logic [ROW_W-1:0] lowest_row(input logic [NUM_ROWS-1:0] r);
    lowest_row = '0;
    for (int i = int'(NUM_ROWS) - 1; i >= 0; i--) begin
      if (r[i]) lowest_row = ROW_W'(i);
    end
  endfunction

  // Scanner / debouncer / repeat state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_SCAN;
      col            <= NUM_COLS'(1);
      col_idx        <= '0;
      scan_cnt       <= '0;
      deb_cnt        <= '0;
      rep_cnt        <= '0;
      rep_first_done <= 1'b0;
      row_idx        <= '0;
      key_code       <= '0;
      valid_key      <= 1'b0;
      key_held       <= 1'b0;
    end else begin
      valid_key <= 1'b0;
      unique case (state)
        ST_SCAN: begin
          if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            if (|row_synced) begin
              row_idx <= lowest_row(row_synced);
              deb_cnt <= '0;
              state   <= ST_DEBOUNCE;
            end else begin
              col     <= {col[NUM_COLS-2:0], col[NUM_COLS-1]};
              col_idx <= (col_idx == COL_W'(NUM_COLS - 1)) ? '0 : col_idx + COL_W'(1);
            end
          end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
          end
        end

        ST_DEBOUNCE: begin
          if (!row_hit) begin
            // Bounce: resume scanning the same column from a fresh settle period.
            scan_cnt <= '0;
            state    <= ST_SCAN;
          end else if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            key_code  <= KEY_W'(row_idx) * KEY_W'(NUM_COLS) + KEY_W'(col_idx);
            valid_key <= 1'b1;
            key_held  <= 1'b1;
            state     <= ST_DRIVE;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end

        ST_DRIVE: begin
          rep_cnt        <= '0;
          rep_first_done <= 1'b0;
          state          <= ST_HOLD;
        end

        ST_HOLD: begin
          if (!row_hit) begin
            deb_cnt <= '0;
            state   <= ST_RELEASE;
          end else if (!repeat_en) begin
            rep_cnt        <= '0;
            rep_first_done <= 1'b0;
          end else if (rep_cnt == rep_last) begin
            valid_key      <= 1'b1;
            rep_cnt        <= '0;
            rep_first_done <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + REP_W'(1);
          end
        end

        ST_RELEASE: begin
          if (row_hit) begin
            // Release bounce: return to HOLD keeping the repeat timing.
            state <= ST_HOLD;
          end else if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            key_held <= 1'b0;
            scan_cnt <= '0;
            state    <= ST_SCAN;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end

        default: state <= ST_SCAN;
      endcase
    end
  end

endmodule
